// File: rtl/and_gate_if.sv
// Signal bundle for the and_gate observability cell. The cell has no handshake:
// inputs are sampled every cycle, outputs are level signals valid after settling.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic             en;
  logic [WIDTH-1:0] Y_q;
  logic             Y_all;
  logic             Y_any;
  logic             cov_clr;
  logic [3:0]       cov;
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output A, B, en, cov_clr,
    input  Y, Y_q, Y_all, Y_any, cov, rise_cnt
  );

  modport slave (
    input  A, B, en, cov_clr,
    output Y, Y_q, Y_all, Y_any, cov, rise_cnt
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND with a registered copy, reduction flags, a saturating count of
// Y_all rising edges and sticky truth-table coverage of bit 0.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  and_gate_if.slave bus
);
  logic [WIDTH-1:0] w_y;
  logic             w_y_all;
  logic             w_y_any;
  logic             w_rise;
  logic             w_cnt_sat;
  logic [1:0]       w_cov_idx;

  logic [WIDTH-1:0] r_y_q;
  logic [3:0]       r_cov;
  logic             r_prev_all;
  logic [CNT_W-1:0] r_rise_cnt;

  // Y is the timing-critical path: kept free of any clock or reset dependency.
  assign w_y       = bus.A & bus.B;
  assign w_y_all   = &w_y;
  assign w_y_any   = |w_y;
  assign w_rise    = w_y_all & ~r_prev_all;
  assign w_cnt_sat = &r_rise_cnt;
  assign w_cov_idx = {bus.A[0], bus.B[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q <= '0;
    end else if (bus.en) begin
      r_y_q <= w_y;
    end
  end

  // Clear beats a same-cycle coverage hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cov <= 4'b0000;
    end else if (bus.cov_clr) begin
      r_cov <= 4'b0000;
    end else begin
      r_cov[w_cov_idx] <= 1'b1;
    end
  end

  // prev_all resets low so a Y_all already high after reset counts as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_all <= 1'b0;
      r_rise_cnt <= '0;
    end else begin
      r_prev_all <= w_y_all;
      if (w_rise && !w_cnt_sat) begin
        r_rise_cnt <= r_rise_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.Y        = w_y;
  assign bus.Y_all    = w_y_all;
  assign bus.Y_any    = w_y_any;
  assign bus.Y_q      = r_y_q;
  assign bus.cov      = r_cov;
  assign bus.rise_cnt = r_rise_cnt;
endmodule

// File: tb/tb_and_gate.sv
// Directed plus randomized bench for and_gate: three instances (1/16, 1/2, 4/16)
// checked against a counting reference model.
module tb_and_gate;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  and_gate_if #(.WIDTH(1), .CNT_W(16)) if0 ();
  and_gate_if #(.WIDTH(1), .CNT_W(2))  if1 ();
  and_gate_if #(.WIDTH(4), .CNT_W(16)) if2 ();

  and_gate #(.WIDTH(1), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  and_gate #(.WIDTH(1), .CNT_W(2))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  and_gate #(.WIDTH(4), .CNT_W(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state: applied inputs, expected registers, unbounded rise events
  logic [3:0] d_a [3];
  logic [3:0] d_b [3];
  logic       d_en;
  logic       d_clr;
  logic [3:0] m_yq [3];
  logic [3:0] m_cov [3];
  longint     m_ev [3];
  bit         m_prev [3];
  logic [3:0] mask [3];
  longint     cmax [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_yq[i]   = '0;
      m_cov[i]  = '0;
      m_ev[i]   = 0;
      m_prev[i] = 1'b0;
    end
  endtask

  // One clock edge of the model: capture, coverage, edge count from plain arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] y;
      bit         all_ones;
      y        = d_a[i] & d_b[i] & mask[i];
      all_ones = (y == mask[i]);
      if (d_en) m_yq[i] = y;
      if (d_clr) m_cov[i] = 4'b0000;
      else m_cov[i][d_a[i][0] * 2 + d_b[i][0]] = 1'b1;
      if (all_ones && !m_prev[i]) m_ev[i]++;
      m_prev[i] = all_ones;
    end
  endtask

  task automatic check_inst(input int i, input string ph);
    logic [63:0] oy, oq, oall, oany, ocov, ocnt;
    logic [3:0]  ey;
    longint      ecnt;
    case (i)
      0: begin oy = 64'(if0.Y); oq = 64'(if0.Y_q); oall = 64'(if0.Y_all);
               oany = 64'(if0.Y_any); ocov = 64'(if0.cov); ocnt = 64'(if0.rise_cnt); end
      1: begin oy = 64'(if1.Y); oq = 64'(if1.Y_q); oall = 64'(if1.Y_all);
               oany = 64'(if1.Y_any); ocov = 64'(if1.cov); ocnt = 64'(if1.rise_cnt); end
      default: begin oy = 64'(if2.Y); oq = 64'(if2.Y_q); oall = 64'(if2.Y_all);
               oany = 64'(if2.Y_any); ocov = 64'(if2.cov); ocnt = 64'(if2.rise_cnt); end
    endcase
    ey   = d_a[i] & d_b[i] & mask[i];
    ecnt = (m_ev[i] > cmax[i]) ? cmax[i] : m_ev[i];
    check($sformatf("d%0d_%s_y", i, ph), oy, 64'(ey));
    check($sformatf("d%0d_%s_all", i, ph), oall, 64'(ey == mask[i]));
    check($sformatf("d%0d_%s_any", i, ph), oany, 64'(ey != 4'b0000));
    check($sformatf("d%0d_%s_yq", i, ph), oq, 64'(m_yq[i]));
    check($sformatf("d%0d_%s_cov", i, ph), ocov, 64'(m_cov[i]));
    check($sformatf("d%0d_%s_cnt", i, ph), ocnt, 64'(ecnt));
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) check_inst(i, ph);
  endtask

  // driver: called at the falling edge; checks combinational outputs, then the edge
  task automatic cycle(input logic a1, input logic b1, input logic [3:0] a4,
                       input logic [3:0] b4, input logic e, input logic c);
    d_a[0] = {3'b000, a1}; d_b[0] = {3'b000, b1};
    d_a[1] = {3'b000, a1}; d_b[1] = {3'b000, b1};
    d_a[2] = a4;           d_b[2] = b4;
    d_en   = e;            d_clr  = c;
    if0.A = a1; if0.B = b1; if0.en = e; if0.cov_clr = c;
    if1.A = a1; if1.B = b1; if1.en = e; if1.cov_clr = c;
    if2.A = a4; if2.B = b4; if2.en = e; if2.cov_clr = c;
    #1;
    check_all("pre");
    @(posedge clk);
    model_edge();
    #1;
    check_all("post");
    @(negedge clk);
  endtask

  task automatic cyc1(input logic a, input logic b, input logic e, input logic c);
    cycle(a, b, {4{a}}, {4{b}}, e, c);
  endtask

  initial begin
    mask[0] = 4'b0001; mask[1] = 4'b0001; mask[2] = 4'b1111;
    cmax[0] = 65535;   cmax[1] = 3;       cmax[2] = 65535;
    for (int i = 0; i < 3; i++) begin d_a[i] = '0; d_b[i] = '0; end
    d_en = 1'b0; d_clr = 1'b0;
    if0.A = '0; if0.B = '0; if0.en = 1'b0; if0.cov_clr = 1'b0;
    if1.A = '0; if1.B = '0; if1.en = 1'b0; if1.cov_clr = 1'b0;
    if2.A = '0; if2.B = '0; if2.en = 1'b0; if2.cov_clr = 1'b0;
    model_reset();
    rst = 1'b1;
    #1;
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;

    // step 1: 00 held
    repeat (10) cyc1(1'b0, 1'b0, 1'b1, 1'b0);
    check("s1_cov", 64'(if0.cov), 64'(4'b0001));
    check("s1_cnt", 64'(if0.rise_cnt), 64'd0);
    // step 2: 10
    repeat (10) cyc1(1'b1, 1'b0, 1'b1, 1'b0);
    check("s2_cov", 64'(if0.cov), 64'(4'b0101));
    // step 3: 01 then 11
    repeat (10) cyc1(1'b0, 1'b1, 1'b1, 1'b0);
    check("s3_cov", 64'(if0.cov), 64'(4'b0111));
    cyc1(1'b1, 1'b1, 1'b1, 1'b0);
    check("s3_yq", 64'(if0.Y_q), 64'd1);
    check("s3_cov15", 64'(if0.cov), 64'(4'b1111));
    check("s3_cnt", 64'(if0.rise_cnt), 64'd1);
    // step 4: en low while toggling
    repeat (3) begin
      cyc1(1'b0, 1'b0, 1'b0, 1'b0);
      cyc1(1'b1, 1'b1, 1'b0, 1'b0);
    end
    cyc1(1'b0, 1'b0, 1'b0, 1'b0);
    check("s4_yq_hold", 64'(if0.Y_q), 64'd1);
    check("s4_cnt", 64'(if0.rise_cnt), 64'd4);
    // step 5: saturation of the 2-bit counter, then clear beats same-cycle set
    repeat (2) begin
      cyc1(1'b1, 1'b1, 1'b1, 1'b0);
      cyc1(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("s5_sat", 64'(if1.rise_cnt), 64'd3);
    check("s5_cnt16", 64'(if0.rise_cnt), 64'd6);
    cyc1(1'b1, 1'b1, 1'b1, 1'b1);
    check("s5_clr", 64'(if1.cov), 64'(4'b0000));

    // randomized phase
    repeat (300) begin
      logic [3:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      cycle(1'($urandom), 1'($urandom), ra, rb, 1'($urandom),
            ($urandom_range(0, 15) == 0));
    end

    // step 6: width-4 pattern, then asynchronous reset between edges
    cycle(1'b1, 1'b1, 4'b1111, 4'b1010, 1'b1, 1'b0);
    check("s6_y", 64'(if2.Y), 64'(4'b1010));
    check("s6_all", 64'(if2.Y_all), 64'd0);
    check("s6_any", 64'(if2.Y_any), 64'd1);
    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    check("s6_arst_y", 64'(if2.Y), 64'(4'b1010));
    check("s6_arst_yq", 64'(if2.Y_q), 64'd0);
    check("s6_arst_cnt", 64'(if0.rise_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // Y_all already high after reset counts on the first edge
    cyc1(1'b1, 1'b1, 1'b1, 1'b0);
    check("s6_first_cnt", 64'(if0.rise_cnt), 64'd1);
    repeat (20) cycle(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                      1'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
